// File: rtl/sram_port_arbiter.sv
// sync_fifo: generic in-order FIFO with exact occupancy count, wrapping pointers.
// Latency: push visible at head next cycle; pop takes effect next cycle.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// sram_port_arbiter: shares one SRAM-like port between inst (M0) and data (M1) requesters.
// Latency: 0-cycle request/payload mux and 0-cycle response routing via in-order owner FIFO.
// Backpressure: grant held until s_addr_ok; new grants stall while MAX_OUTST transactions are in flight.
module sram_port_arbiter #(
    parameter int MAX_OUTST  = 2,
    parameter int DATA_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           m0_req,
    input  logic                           m0_wr,
    input  logic [1:0]                     m0_size,
    input  logic [3:0]                     m0_wstrb,
    input  logic [31:0]                    m0_addr,
    input  logic [31:0]                    m0_wdata,
    output logic                           m0_addr_ok,
    output logic                           m0_data_ok,
    output logic [31:0]                    m0_rdata,
    input  logic                           m1_req,
    input  logic                           m1_wr,
    input  logic [1:0]                     m1_size,
    input  logic [3:0]                     m1_wstrb,
    input  logic [31:0]                    m1_addr,
    input  logic [31:0]                    m1_wdata,
    output logic                           m1_addr_ok,
    output logic                           m1_data_ok,
    output logic [31:0]                    m1_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [3:0]                     s_wstrb,
    output logic [31:0]                    s_addr,
    output logic [31:0]                    s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [31:0]                    s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           proto_err
);
    localparam int CW = $clog2(MAX_OUTST+1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_nxt;
    logic   grant_vld;
    logic   grant_id;
    logic   full;
    logic   handshake;
    logic   pop;
    logic   fifo_empty;
    logic   head_id;

    assign full = (outst_cnt == CW'(MAX_OUTST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (!full && (m0_req || m1_req)) begin
                    grant_vld = 1'b1;
                    if (m0_req && m1_req) grant_id = (DATA_FIRST != 0);
                    else                  grant_id = m1_req;
                    if (!s_addr_ok) state_nxt = grant_id ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
                if (s_addr_ok) state_nxt = IDLE;
            end
            LOCK1: begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
                if (s_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request is suppressed while reset is held so the bus is quiet immediately.
    assign s_req   = grant_vld & reset;
    assign s_wr    = grant_id ? m1_wr    : m0_wr;
    assign s_size  = grant_id ? m1_size  : m0_size;
    assign s_wstrb = grant_id ? m1_wstrb : m0_wstrb;
    assign s_addr  = grant_id ? m1_addr  : m0_addr;
    assign s_wdata = grant_id ? m1_wdata : m0_wdata;

    assign handshake  = s_req & s_addr_ok;
    assign m0_addr_ok = handshake & ~grant_id;
    assign m1_addr_ok = handshake &  grant_id;

    // Pop uses the pre-push head: a response never bypasses into its own addr cycle.
    assign pop        = s_data_ok & ~fifo_empty;
    assign m0_data_ok = pop & ~head_id;
    assign m1_data_ok = pop &  head_id;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTST)) u_id_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (handshake),
        .push_dat (grant_id),
        .pop      (pop),
        .head_dat (head_id),
        .count    (outst_cnt),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        proto_err <= 1'b0;
        else if (s_data_ok && fifo_empty) proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (MAX_OUTST=2, DATA_FIRST=1): inputs change 1 time unit
// after the rising edge, outputs are checked on the falling edge of the same cycle.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic [1:0]  outst_cnt;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.MAX_OUTST(2), .DATA_FIRST(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;

        sample();
        chk("rst_s_req", s_req, 0);
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_data_ok", {m0_data_ok, m1_data_ok, m0_addr_ok, m1_addr_ok}, 0);
        next_cycle();
        reset = 1'b1;

        // T1: lone m1 read, response two cycles later
        next_cycle();
        m1_req = 1; m1_addr = 32'h100; s_addr_ok = 1;
        sample();
        chk("t1_m1_addr_ok", m1_addr_ok, 1);
        chk("t1_m0_addr_ok", m0_addr_ok, 0);
        chk("t1_s_addr", s_addr, 32'h100);
        chk("t1_s_wr", s_wr, 0);
        next_cycle();
        m1_req = 0; s_addr_ok = 0;
        sample();
        chk("t1_cnt_c1", outst_cnt, 1);
        chk("t1_s_req_c1", s_req, 0);
        next_cycle();
        s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        sample();
        chk("t1_m1_data_ok", m1_data_ok, 1);
        chk("t1_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("t1_m0_data_ok", m0_data_ok, 0);
        next_cycle();
        s_data_ok = 0;
        sample();
        chk("t1_cnt_end", outst_cnt, 0);

        // T2: simultaneous requests, data side first
        next_cycle();
        m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300; s_addr_ok = 1;
        sample();
        chk("t2_m1_first", m1_addr_ok, 1);
        chk("t2_m0_wait", m0_addr_ok, 0);
        chk("t2_s_addr_c0", s_addr, 32'h300);
        next_cycle();
        m1_req = 0;
        sample();
        chk("t2_m0_second", m0_addr_ok, 1);
        chk("t2_s_addr_c1", s_addr, 32'h200);
        chk("t2_cnt_c1", outst_cnt, 1);
        next_cycle();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h11111111;
        sample();
        chk("t2_cnt_c2", outst_cnt, 2);
        chk("t2_route1", {m0_data_ok, m1_data_ok}, 2'b01);
        next_cycle();
        s_rdata = 32'h22222222;
        sample();
        chk("t2_route2", {m0_data_ok, m1_data_ok}, 2'b10);
        chk("t2_m0_rdata", m0_rdata, 32'h22222222);
        next_cycle();
        s_data_ok = 0;
        sample();
        chk("t2_cnt_end", outst_cnt, 0);

        // T3: m0 locked while bridge stalls, m1 waits
        next_cycle();
        m0_req = 1; m0_addr = 32'h400;
        sample();
        chk("t3_s_req", s_req, 1);
        chk("t3_s_addr_c0", s_addr, 32'h400);
        next_cycle();
        m1_req = 1; m1_addr = 32'h500;
        sample();
        chk("t3_lock_addr_c1", s_addr, 32'h400);
        chk("t3_m1_blocked_c1", m1_addr_ok, 0);
        next_cycle();
        sample();
        chk("t3_lock_addr_c2", s_addr, 32'h400);
        next_cycle();
        s_addr_ok = 1;
        sample();
        chk("t3_m0_hs", {m0_addr_ok, m1_addr_ok}, 2'b10);
        chk("t3_hs_addr", s_addr, 32'h400);
        next_cycle();
        m0_req = 0;
        sample();
        chk("t3_m1_hs", {m0_addr_ok, m1_addr_ok}, 2'b01);
        chk("t3_m1_addr", s_addr, 32'h500);
        next_cycle();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000000A;
        sample();
        chk("t3_cnt_full", outst_cnt, 2);
        chk("t3_route_m0", {m0_data_ok, m1_data_ok}, 2'b10);
        next_cycle();
        sample();
        chk("t3_route_m1", {m0_data_ok, m1_data_ok}, 2'b01);
        next_cycle();
        s_data_ok = 0;
        sample();
        chk("t3_cnt_end", outst_cnt, 0);

        // T4: fill to MAX_OUTST, grant blocked until a response drains one entry
        next_cycle();
        m0_req = 1; m0_addr = 32'h600; s_addr_ok = 1;
        sample();
        chk("t4_hs0", m0_addr_ok, 1);
        next_cycle();
        m0_addr = 32'h604;
        sample();
        chk("t4_hs1", m0_addr_ok, 1);
        next_cycle();
        m0_addr = 32'h608;
        sample();
        chk("t4_cnt_full", outst_cnt, 2);
        chk("t4_s_req_blocked", s_req, 0);
        chk("t4_no_hs", m0_addr_ok, 0);
        next_cycle();
        s_data_ok = 1; s_rdata = 32'h33333333;
        sample();
        chk("t4_pop_still_full", s_req, 0);
        chk("t4_pop_route", m0_data_ok, 1);
        next_cycle();
        s_data_ok = 0;
        sample();
        chk("t4_cnt_after_pop", outst_cnt, 1);
        chk("t4_grant_resumes", {s_req, m0_addr_ok}, 2'b11);
        chk("t4_resume_addr", s_addr, 32'h608);
        next_cycle();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        sample();
        chk("t4_cnt_refull", outst_cnt, 2);
        chk("t4_drain_route", m0_data_ok, 1);

        // T5: cnt=1, push and pop in the same cycle
        next_cycle();
        m1_req = 1; m1_addr = 32'h700; s_addr_ok = 1; s_rdata = 32'h44444444;
        sample();
        chk("t5_cnt_before", outst_cnt, 1);
        chk("t5_m1_hs", m1_addr_ok, 1);
        chk("t5_route_older", {m0_data_ok, m1_data_ok}, 2'b10);
        next_cycle();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 0;
        sample();
        chk("t5_cnt_same", outst_cnt, 1);
        chk("t5_no_proto_err", proto_err, 0);
        next_cycle();
        s_data_ok = 1; s_rdata = 32'h55555555;
        sample();
        chk("t5_m1_resp", {m0_data_ok, m1_data_ok}, 2'b01);
        chk("t5_m1_rdata", m1_rdata, 32'h55555555);
        next_cycle();
        s_data_ok = 0;
        sample();
        chk("t5_cnt_end", outst_cnt, 0);

        // T6: spurious response, then reset mid-burst
        next_cycle();
        s_data_ok = 1;
        sample();
        chk("t6_no_route", {m0_data_ok, m1_data_ok}, 2'b00);
        chk("t6_cnt_empty", outst_cnt, 0);
        next_cycle();
        s_data_ok = 0; m0_req = 1; m0_addr = 32'h800; s_addr_ok = 1;
        sample();
        chk("t6_proto_err", proto_err, 1);
        chk("t6_hs", m0_addr_ok, 1);
        next_cycle();
        m1_req = 1; m1_addr = 32'h900; s_addr_ok = 0;
        sample();
        chk("t6_cnt_1", outst_cnt, 1);
        chk("t6_m1_prio_addr", s_addr, 32'h900);
        next_cycle();
        s_addr_ok = 1;
        reset = 1'b0;
        #1;
        chk("t6_rst_cnt", outst_cnt, 0);
        chk("t6_rst_proto_err", proto_err, 0);
        chk("t6_rst_s_req", s_req, 0);
        chk("t6_rst_addr_ok", {m0_addr_ok, m1_addr_ok}, 2'b00);
        next_cycle();
        reset = 1'b1; m0_req = 0; m1_req = 0; s_addr_ok = 0;
        sample();
        chk("t6_post_rst_idle", s_req, 0);
        chk("t6_post_rst_cnt", outst_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
